bcd_timer_gen: RTL and testbench
================================

BCD_TIMER_GEN -- requirements
Module: bcd_timer_gen

Interface
REQ-001 SHALL have parameter MIN_DIGITS, default 1: number of BCD minute digits (1..3).
REQ-002 SHALL have parameter TICK_DIV, default 1: clock cycles per one-second count step (>=1).
REQ-003 SHALL have port clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port clearn  input  1  reset; one clock; reset is synchronous and active-low.
REQ-005 SHALL have port loadn  input  1  active-low digit shift-load strobe, sampled each edge.
REQ-006 SHALL have port enable  input  1  count enable (magnetron on).
REQ-007 SHALL have port up  input  1  direction; 1 = count up, 0 = count down.
REQ-008 SHALL have port data  input  4  BCD digit to shift in.
REQ-009 SHALL have port sec_ones  output  4  seconds units digit.
REQ-010 SHALL have port sec_tens  output  4  seconds tens digit.
REQ-011 SHALL have port mins  output  4*MIN_DIGITS  minute digits; least-significant digit in bits [3:0].
REQ-012 SHALL have port zero  output  1  high while all digits are 0.
REQ-013 SHALL have port done  output  1  one-cycle pulse when a down-count reaches zero.

Function
REQ-014 SHALL, on an edge with loadn=0 and enable=0, shift digits left: data->sec_ones->sec_tens->mins[3:0]->...; top minute digit discarded.
REQ-015 SHALL clamp loaded data values 10..15 to 9.
REQ-016 SHALL ignore loadn while enable=1.
REQ-017 SHALL run a prescaler 0..TICK_DIV-1 while enable=1 and loadn=1; a tick occurs on the edge where prescaler = TICK_DIV-1, after which it wraps to 0.
REQ-018 SHALL hold the prescaler at 0 while enable=0 or loadn=0.
REQ-019 SHALL, on a down tick with nonzero value, decrement sec_ones; borrow: sec_ones 0->9 and decrement sec_tens; sec_tens 0->5 and decrement mins chain; each minute digit 0->9 with borrow.
REQ-020 SHALL hold all digits at 0 on a down tick when zero=1; no done pulse.
REQ-021 SHALL, on an up tick, increment sec_ones; carry: sec_ones 9->0 and increment sec_tens; sec_tens >=5 with carry ->0 and increment mins chain; minute digits 9->0 with carry.
REQ-022 SHALL saturate on an up tick when all minute digits are 9, sec_tens >=5 and sec_ones = 9 (value held).
REQ-023 SHALL accept loaded sec_tens values 6..9 unchanged; down-count decrements them arithmetically.
REQ-024 SHALL drive zero combinationally from the digit registers.
REQ-025 SHALL assert done for exactly one cycle, registered, on the edge where a down tick changes the value from nonzero to zero.
REQ-026 SHALL have zero latency from tick edge to updated digits (digits registered on that edge).
REQ-027 SHALL give clearn=0 priority over loadn, enable and tick on the same edge.

Reset
REQ-028 SHALL, on an edge with clearn=0, set all digits to 0, prescaler to 0, done to 0; zero therefore 1.
REQ-029 SHALL, on reset mid-countdown, suppress done.

Structure
REQ-030 SHALL place BCD digit width (4), max BCD digit (9) and max seconds-tens digit (5) in shared package timer_pkg.
REQ-031 SHALL instantiate sub-module bcd_digit_cnt (one digit, modulus parameter, up/down, carry/borrow in/out, shift-load) per digit.

Verification
REQ-032 SHALL test: MIN_DIGITS=1, TICK_DIV=1, load 7 with enable=0 -> 0:07, zero=0; enable 7 cycles -> 0:00, done pulses once, zero=1; further cycles hold 0:00.
REQ-033 SHALL test: load 1,3,0 -> mins=1, 1:30; one down tick -> 1:29; 30 further ticks -> 0:59.
REQ-034 SHALL test: clearn=0 at 0:04 during countdown -> next edge 0:00, zero=1, done stays 0.
REQ-035 SHALL test: up=1 from 9:58 -> 9:59 after one tick, then holds 9:59; data=12 loaded -> digit 9.
REQ-036 SHALL test: TICK_DIV=4, 8 enabled cycles from 0:10 -> 0:08; enable dropped after 3 cycles then restored -> next step 4 cycles later.
REQ-037 SHALL test: loadn=0 with enable=1 at 0:05 -> no shift, countdown continues to 0:04.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared BCD constants and digit helpers for the countdown/count-up timer.
// Latency: n/a (constants and a pure combinational helper).
// Backpressure: n/a.
package timer_pkg;

    localparam int                 BCD_W        = 4;
    localparam logic [BCD_W-1:0]   BCD_MAX      = 4'd9;
    localparam logic [BCD_W-1:0]   SEC_TENS_MAX = 4'd5;

    // Keypad entries above 9 are not valid BCD; treat them as 9.
    function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_digit_cnt.sv
// One BCD digit of the timer: shift-load, or step up/down with carry/borrow.
// Latency: digit updates on the clock edge; step_out is combinational from q.
// Backpressure: none; hold freezes the step (saturation / zero hold) for the whole chain.
//
// Ports:
//   clock, clearn        - clock, synchronous active-low clear
//   shift_en, shift_in   - load shift_in into this digit (digit shift register)
//   step_in              - carry (up) or borrow (down) arriving at this digit
//   hold                 - suppress the step on every digit this cycle
//   up                   - step direction, 1 = increment
//   step_out             - carry/borrow passed to the next more-significant digit
//   q                    - digit value
module bcd_digit_cnt
    import timer_pkg::*;
#(
    parameter logic [BCD_W-1:0] MOD_MAX = BCD_MAX
) (
    input  logic             clock,
    input  logic             clearn,
    input  logic             shift_en,
    input  logic [BCD_W-1:0] shift_in,
    input  logic             step_in,
    input  logic             hold,
    input  logic             up,
    output logic             step_out,
    output logic [BCD_W-1:0] q
);

    logic at_limit;

    // '>=' on the way up lets loaded out-of-range tens (6..9) wrap on carry.
    assign at_limit = up ? (q >= MOD_MAX) : (q == '0);
    // Carry/borrow does not depend on hold, so the carry out of the
    // top digit tells the parent that the whole value is saturated or zero.
    assign step_out = step_in && at_limit;

    always_ff @(posedge clock) begin
        if (!clearn) begin
            q <= '0;
        end else if (shift_en) begin
            q <= shift_in;
        end else if (step_in && !hold) begin
            if (up) begin
                q <= at_limit ? '0 : q + BCD_W'(1);
            end else begin
                q <= at_limit ? MOD_MAX : q - BCD_W'(1);
            end
        end
    end

endmodule

// File: rtl/bcd_timer_gen.sv
// BCD mm:ss timer: keypad digit shift-load, prescaled up/down count, zero flag, done pulse.
// Latency: digits and done update on the tick edge; zero is combinational from the digits.
// Backpressure: none; loadn pauses the prescaler, enable gates counting and blocks loading.
//
// Ports:
//   clock, clearn        - clock, synchronous active-low clear (highest priority)
//   loadn, data          - active-low shift strobe and BCD digit entering sec_ones
//   enable, up           - count enable and direction (1 = up)
//   sec_ones, sec_tens   - seconds digits
//   mins                 - minute digits, least significant in [3:0]
//   zero, done           - all-digits-zero flag, one-cycle end-of-countdown pulse
module bcd_timer_gen
    import timer_pkg::*;
#(
    parameter int MIN_DIGITS = 1,
    parameter int TICK_DIV   = 1
) (
    input  logic                        clock,
    input  logic                        clearn,
    input  logic                        loadn,
    input  logic                        enable,
    input  logic                        up,
    input  logic [BCD_W-1:0]            data,
    output logic [BCD_W-1:0]            sec_ones,
    output logic [BCD_W-1:0]            sec_tens,
    output logic [BCD_W*MIN_DIGITS-1:0] mins,
    output logic                        zero,
    output logic                        done
);

    // Digit index 0 = sec_ones, 1 = sec_tens, 2.. = minutes.
    localparam int               N_DIG      = MIN_DIGITS + 2;
    localparam int               PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0]    presc;
    logic             run;
    logic             tick;
    logic             shift_en;
    logic             hold;
    logic             one_left;
    logic [N_DIG:0]   step;
    logic [BCD_W-1:0] dq [N_DIG];

    assign run      = enable && loadn;
    assign tick     = run && (presc == PRESC_LAST);
    assign shift_en = !loadn && !enable;

    // A step rippling out of the top digit means every digit is at its limit:
    // all 9s (with tens >= 5) going up, all zeros going down. Either way hold.
    assign step[0] = tick;
    assign hold    = step[N_DIG];

    generate
        for (genvar i = 0; i < N_DIG; i++) begin : g_dig
            localparam logic [BCD_W-1:0] MAXV = (i == 1) ? SEC_TENS_MAX : BCD_MAX;
            logic [BCD_W-1:0] src;

            if (i == 0) begin : g_src_data
                assign src = bcd_clamp(data);
            end else begin : g_src_prev
                assign src = dq[i-1];
            end

            bcd_digit_cnt #(
                .MOD_MAX (MAXV)
            ) u_digit (
                .clock    (clock),
                .clearn   (clearn),
                .shift_en (shift_en),
                .shift_in (src),
                .step_in  (step[i]),
                .hold     (hold),
                .up       (up),
                .step_out (step[i+1]),
                .q        (dq[i])
            );
        end

        for (genvar m = 0; m < MIN_DIGITS; m++) begin : g_mins
            assign mins[BCD_W*m +: BCD_W] = dq[m+2];
        end
    endgenerate

    assign sec_ones = dq[0];
    assign sec_tens = dq[1];

    // one_left: value is exactly 0:01, so the next down step lands on zero.
    always_comb begin
        zero     = 1'b1;
        one_left = (dq[0] == BCD_W'(1));
        for (int i = 0; i < N_DIG; i++) begin
            if (dq[i] != '0) zero = 1'b0;
        end
        for (int i = 1; i < N_DIG; i++) begin
            if (dq[i] != '0) one_left = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!clearn) begin
            presc <= '0;
            done  <= 1'b0;
        end else begin
            done <= tick && !up && one_left;
            if (run) begin
                presc <= tick ? '0 : presc + PW'(1);
            end else begin
                presc <= '0;
            end
        end
    end

endmodule

// File: tb/tb_bcd_timer_gen.sv
// Self-checking bench for bcd_timer_gen: two instances (1 minute digit / every cycle,
// 2 minute digits / every 4th cycle) share stimulus and are compared each cycle
// against a seconds/minutes arithmetic model, plus directed literal checks.
module tb_bcd_timer_gen;

    logic       clock;
    logic       clearn;
    logic       loadn;
    logic       enable;
    logic       up;
    logic [3:0] data;

    logic [3:0] a_ones, a_tens, a_mins;
    logic       a_zero, a_done;
    logic [3:0] b_ones, b_tens;
    logic [7:0] b_mins;
    logic       b_zero, b_done;

    int tests = 0;
    int fails = 0;

    bcd_timer_gen #(.MIN_DIGITS(1), .TICK_DIV(1)) u_dut_a (
        .clock(clock), .clearn(clearn), .loadn(loadn), .enable(enable), .up(up),
        .data(data), .sec_ones(a_ones), .sec_tens(a_tens), .mins(a_mins),
        .zero(a_zero), .done(a_done)
    );

    bcd_timer_gen #(.MIN_DIGITS(2), .TICK_DIV(4)) u_dut_b (
        .clock(clock), .clearn(clearn), .loadn(loadn), .enable(enable), .up(up),
        .data(data), .sec_ones(b_ones), .sec_tens(b_tens), .mins(b_mins),
        .zero(b_zero), .done(b_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: minutes as an integer, seconds as tens*10+ones (0..99).
    int   md [2] = '{1, 2};
    int   td [2] = '{1, 4};
    int   m_min [2];
    int   m_sec [2];
    int   m_pre [2];
    logic m_done [2];

    function automatic int pow10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [15:0] to_bcd(input int v, input int nd);
        logic [15:0] r = '0;
        int x = v;
        for (int i = 0; i < nd; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (!clearn) begin
                m_min[k] = 0; m_sec[k] = 0; m_pre[k] = 0; m_done[k] = 1'b0;
            end else begin
                logic tk, nd;
                int d, ones, tens;
                tk = enable && loadn && (m_pre[k] == td[k] - 1);
                if (enable && loadn) m_pre[k] = tk ? 0 : m_pre[k] + 1;
                else                 m_pre[k] = 0;
                nd = 1'b0;
                if (!loadn && !enable) begin
                    d        = (int'(data) > 9) ? 9 : int'(data);
                    ones     = m_sec[k] % 10;
                    tens     = m_sec[k] / 10;
                    m_min[k] = (m_min[k] * 10 + tens) % pow10(md[k]);
                    m_sec[k] = ones * 10 + d;
                end else if (tk) begin
                    if (!up) begin
                        if (m_min[k] != 0 || m_sec[k] != 0) begin
                            if (m_sec[k] > 0) m_sec[k] = m_sec[k] - 1;
                            else begin m_min[k] = m_min[k] - 1; m_sec[k] = 59; end
                            nd = (m_min[k] == 0 && m_sec[k] == 0);
                        end
                    end else begin
                        ones = m_sec[k] % 10;
                        tens = m_sec[k] / 10;
                        if (ones == 9 && tens >= 5) begin
                            if (m_min[k] < pow10(md[k]) - 1) begin
                                m_min[k] = m_min[k] + 1;
                                m_sec[k] = 0;
                            end
                        end else begin
                            m_sec[k] = m_sec[k] + 1;
                        end
                    end
                end
                m_done[k] = nd;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("a_ones", 16'(a_ones), 16'(m_sec[0] % 10));
        chk("a_tens", 16'(a_tens), 16'(m_sec[0] / 10));
        chk("a_mins", 16'(a_mins), to_bcd(m_min[0], 1));
        chk("a_zero", 16'(a_zero), 16'(m_min[0] == 0 && m_sec[0] == 0));
        chk("a_done", 16'(a_done), 16'(m_done[0]));
        chk("b_ones", 16'(b_ones), 16'(m_sec[1] % 10));
        chk("b_tens", 16'(b_tens), 16'(m_sec[1] / 10));
        chk("b_mins", 16'(b_mins), to_bcd(m_min[1], 2));
        chk("b_zero", 16'(b_zero), 16'(m_min[1] == 0 && m_sec[1] == 0));
        chk("b_done", 16'(b_done), 16'(m_done[1]));
    endtask

    task automatic cyc();
        @(posedge clock);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic load_digit(input logic [3:0] d);
        enable = 1'b0;
        loadn  = 1'b0;
        data   = d;
        cyc();
        loadn  = 1'b1;
    endtask

    task automatic clear_pulse();
        enable = 1'b0;
        clearn = 1'b0;
        cyc();
        clearn = 1'b1;
    endtask

    int dcount;

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_min[k] = 0; m_sec[k] = 0; m_pre[k] = 0; m_done[k] = 1'b0;
        end
        clearn = 1'b0; loadn = 1'b1; enable = 1'b0; up = 1'b0; data = 4'd0;
        repeat (2) cyc();
        chk("rst_zero_a", 16'(a_zero), 16'd1);
        chk("rst_done_a", 16'(a_done), 16'd0);
        clearn = 1'b1;

        // Load 7, count down to zero, single done pulse, then hold.
        load_digit(4'd7);
        chk("load7_ones", 16'(a_ones), 16'd7);
        chk("load7_zero", 16'(a_zero), 16'd0);
        enable = 1'b1; up = 1'b0; dcount = 0;
        repeat (7) begin cyc(); if (a_done === 1'b1) dcount++; end
        chk("cd7_ones", 16'(a_ones), 16'd0);
        chk("cd7_zero", 16'(a_zero), 16'd1);
        repeat (3) begin cyc(); if (a_done === 1'b1) dcount++; end
        chk("cd7_done_count", 16'(dcount), 16'd1);
        chk("cd7_hold_ones", 16'(a_ones), 16'd0);

        // Load 1,3,0 -> 1:30, borrow across the minute boundary.
        load_digit(4'd1); load_digit(4'd3); load_digit(4'd0);
        chk("l130_mins", 16'(a_mins), 16'd1);
        chk("l130_tens", 16'(a_tens), 16'd3);
        enable = 1'b1;
        cyc();
        chk("d129_tens", 16'(a_tens), 16'd2);
        chk("d129_ones", 16'(a_ones), 16'd9);
        repeat (30) cyc();
        chk("d059_mins", 16'(a_mins), 16'd0);
        chk("d059_tens", 16'(a_tens), 16'd5);
        chk("d059_ones", 16'(a_ones), 16'd9);

        // Clear at 0:04 and at 0:01 while counting: zeros, no done.
        clear_pulse();
        load_digit(4'd5);
        enable = 1'b1;
        cyc();
        chk("clr_pre_ones", 16'(a_ones), 16'd4);
        clearn = 1'b0;
        cyc();
        chk("clr4_ones", 16'(a_ones), 16'd0);
        chk("clr4_zero", 16'(a_zero), 16'd1);
        chk("clr4_done", 16'(a_done), 16'd0);
        clearn = 1'b1;
        load_digit(4'd1);
        enable = 1'b1; clearn = 1'b0;
        cyc();
        chk("clr1_done", 16'(a_done), 16'd0);
        clearn = 1'b1; enable = 1'b0;
        repeat (2) begin cyc(); chk("clr1_done_after", 16'(a_done), 16'd0); end

        // Count up from 9:58, saturate at 9:59; data 12 loads as 9.
        clear_pulse();
        load_digit(4'd9); load_digit(4'd5); load_digit(4'd8);
        chk("l958_mins", 16'(a_mins), 16'd9);
        up = 1'b1; enable = 1'b1;
        cyc();
        chk("u959_ones", 16'(a_ones), 16'd9);
        repeat (3) cyc();
        chk("sat_mins", 16'(a_mins), 16'd9);
        chk("sat_tens", 16'(a_tens), 16'd5);
        chk("sat_ones", 16'(a_ones), 16'd9);
        load_digit(4'd12);
        chk("clamp12", 16'(a_ones), 16'd9);
        up = 1'b0;

        // Prescaled instance: 0:10 -> 0:08 in 8 cycles; enable gap restarts prescaler.
        clear_pulse();
        load_digit(4'd1); load_digit(4'd0);
        chk("b_l010_tens", 16'(b_tens), 16'd1);
        enable = 1'b1;
        repeat (8) cyc();
        chk("b_008_tens", 16'(b_tens), 16'd0);
        chk("b_008_ones", 16'(b_ones), 16'd8);
        repeat (3) cyc();
        enable = 1'b0;
        cyc();
        enable = 1'b1;
        repeat (3) cyc();
        chk("b_gap_hold", 16'(b_ones), 16'd8);
        cyc();
        chk("b_gap_step", 16'(b_ones), 16'd7);

        // loadn while enabled: no shift, then counting resumes.
        clear_pulse();
        load_digit(4'd5);
        enable = 1'b1; loadn = 1'b0; data = 4'd3;
        cyc();
        chk("ldn_en_tens", 16'(a_tens), 16'd0);
        loadn = 1'b1;
        cyc();
        chk("ldn_en_ones", 16'(a_ones), 16'd4);

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            clearn = ($urandom_range(0, 49) != 0);
            loadn  = ($urandom_range(0, 3) != 0);
            enable = 1'($urandom_range(0, 1));
            up     = ($urandom_range(0, 2) == 0);
            data   = 4'($urandom_range(0, 15));
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
